// File: rtl/lab1_qsys_onchip_memory_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port on-chip RAM with
// read latency 1. Round-robin grant, per-master waitrequest, pipelined
// readdatavalid and out-of-range protection with a sticky error flag.
//
// Handshake: a master presents read or write with address/data and holds
// them stable while its waitrequest is high; the transfer is accepted in the
// cycle waitrequest is low. Read data for an accepted read is returned on the
// shared readdata bus with that master's readdatavalid high for exactly one
// cycle, in the cycle after acceptance.
module lab1_qsys_onchip_memory_arbiter #(
  parameter int                ADDR_W   = 14,
  parameter int                DATA_W   = 32,
  parameter int unsigned       DEPTH    = 10000,
  parameter logic [DATA_W-1:0] OOR_DATA = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic                  oor_error
);

  logic              ready;
  logic              last_grant;
  logic              rd_pending;
  logic              rd_owner;
  logic              rd_oor;

  logic              req0;
  logic              req1;
  logic              grant_valid;
  logic              grant;
  logic [ADDR_W-1:0] win_address;
  logic              win_write;
  logic              win_read;
  logic              win_oor;

  // A simultaneous read+write from one master is treated as a write.
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Round-robin pick: on a tie the master that did not win last time goes.
  always_comb begin
    grant_valid = ready & (req0 | req1);
    if (req0 & req1) begin
      grant = ~last_grant;
    end else begin
      grant = req1;
    end
  end

  // Winner's request steers the RAM port; out-of-range addresses never select it.
  always_comb begin
    win_address = grant ? m1_address : m0_address;
    win_write   = grant ? m1_write : m0_write;
    win_read    = (grant ? m1_read : m0_read) & ~win_write;
    win_oor     = ({{(32-ADDR_W){1'b0}}, win_address} >= DEPTH);

    mem_address    = win_address;
    mem_writedata  = grant ? m1_writedata : m0_writedata;
    mem_byteenable = grant ? m1_byteenable : m0_byteenable;
    mem_chipselect = grant_valid & ~win_oor;
    mem_write      = grant_valid & win_write;
    mem_clken      = ready;
  end

  assign m0_waitrequest = ~(grant_valid & ~grant);
  assign m1_waitrequest = ~(grant_valid & grant);

  // Read return path: RAM data arrives one cycle after the granted read.
  assign m0_readdata      = rd_oor ? OOR_DATA : mem_readdata;
  assign m1_readdata      = m0_readdata;
  assign m0_readdatavalid = rd_pending & ~rd_owner;
  assign m1_readdatavalid = rd_pending & rd_owner;

  // Ready comes up one edge after reset release; no grant before that.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready <= 1'b0;
    end else begin
      ready <= 1'b1;
    end
  end

  // Remember the last winner for the round-robin tie break.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (grant_valid) begin
      last_grant <= grant;
    end
  end

  // Track the single outstanding read; reset discards it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
      rd_oor     <= 1'b0;
    end else begin
      rd_pending <= grant_valid & win_read;
      if (grant_valid & win_read) begin
        rd_owner <= grant;
        rd_oor   <= win_oor;
      end
    end
  end

  // Sticky flag for any accepted out-of-range access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oor_error <= 1'b0;
    end else if (grant_valid & win_oor) begin
      oor_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lab1_qsys_onchip_memory_arbiter.sv
// Bench for the two-master on-chip memory arbiter: behavioural RAM behind the
// mem_* port, a reference memory and round-robin model, and an expected queue
// of {owner, data} for read returns.
module tb_lab1_qsys_onchip_memory_arbiter;

  localparam int          DEPTH    = 10000;
  localparam logic [31:0] OOR_DATA = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] m0_address = '0;
  logic        m0_read = 1'b0;
  logic        m0_write = 1'b0;
  logic [31:0] m0_writedata = '0;
  logic [3:0]  m0_byteenable = '0;
  logic        m0_waitrequest;
  logic [31:0] m0_readdata;
  logic        m0_readdatavalid;
  logic [13:0] m1_address = '0;
  logic        m1_read = 1'b0;
  logic        m1_write = 1'b0;
  logic [31:0] m1_writedata = '0;
  logic [3:0]  m1_byteenable = '0;
  logic        m1_waitrequest;
  logic [31:0] m1_readdata;
  logic        m1_readdatavalid;
  logic [13:0] mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_clken;
  logic [31:0] mem_readdata;
  logic        oor_error;

  lab1_qsys_onchip_memory_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_byteenable    (m0_byteenable),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_byteenable    (m1_byteenable),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_byteenable   (mem_byteenable),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata),
    .oor_error        (oor_error)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- RAM model (latency 1) ----------------
  logic [31:0] ram [0:DEPTH-1];
  logic        ram_inited = 1'b0;

  function automatic logic [31:0] init_word(int i);
    return (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (!ram_inited) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
      ram_inited <= 1'b1;
    end else if (mem_clken) begin
      if (mem_chipselect && mem_write && int'(mem_address) < DEPTH) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end
      if (int'(mem_address) < DEPTH) mem_readdata <= ram[mem_address];
    end
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic        mdl_ready = 1'b0;
  logic        mdl_last  = 1'b1;
  logic        mdl_oor   = 1'b0;
  logic        gnt0 = 1'b0;
  logic        gnt1 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One bus cycle: predict grant, check the RAM-side outputs, update the model.
  task automatic step();
    logic r0, r1, gv, g, wr, oor;
    logic [13:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    @(negedge clk);
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    gv = mdl_ready & (r0 | r1);
    g  = (r0 & r1) ? ~mdl_last : r1;
    gnt0 = gv & ~g;
    gnt1 = gv & g;
    check("m0_waitrequest", m0_waitrequest, !gnt0);
    check("m1_waitrequest", m1_waitrequest, !gnt1);
    check("mem_clken", mem_clken, mdl_ready);
    check("oor_error", oor_error, mdl_oor);
    if (gv) begin
      a   = g ? m1_address : m0_address;
      d   = g ? m1_writedata : m0_writedata;
      be  = g ? m1_byteenable : m0_byteenable;
      wr  = g ? m1_write : m0_write;
      oor = int'(a) >= DEPTH;
      check("mem_chipselect", mem_chipselect, !oor);
      check("mem_write", mem_write, wr);
      check("mem_address", mem_address, a);
      if (wr) begin
        if (!oor) begin
          check("mem_writedata", mem_writedata, d);
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
        end
      end else begin
        exp_q.push_back({g, oor ? OOR_DATA : ref_mem[a]});
      end
      if (oor) mdl_oor = 1'b1;
      mdl_last = g;
    end else begin
      check("mem_chipselect_idle", mem_chipselect, 1'b0);
    end
    @(posedge clk);
    if (reset_n) mdl_ready = 1'b1;
    #1;
  endtask

  task automatic set_req(input logic m, input logic rd, input logic wr,
                         input logic [13:0] a, input logic [31:0] d, input logic [3:0] be);
    if (m) begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end else begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end
  endtask

  // Single transfer from one master, held until accepted (bounded).
  task automatic do_op(input logic m, input logic wr, input logic [13:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    logic got;
    got = 1'b0;
    set_req(m, !wr, wr, a, d, be);
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      got = m ? gnt1 : gnt0;
    end
    check("op_granted", got, 1'b1);
    set_req(m, 1'b0, 1'b0, a, d, be);
  endtask

  task automatic rand_op(input logic m);
    int unsigned k;
    logic [13:0] a;
    k = $urandom_range(0, 3);
    a = ($urandom_range(0, 19) == 0) ? 14'(10000 + $urandom_range(0, 5))
                                     : 14'($urandom_range(0, 15));
    if (k == 1) set_req(m, 1'b1, 1'b0, a, $urandom, 4'hF);
    else if (k >= 2) set_req(m, 1'b0, 1'b1, a, $urandom, 4'($urandom_range(1, 15)));
  endtask

  // ---------------- read-return monitor ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (reset_n && (m0_readdatavalid || m1_readdatavalid)) begin
      check("rdv_exclusive", {31'b0, m0_readdatavalid & m1_readdatavalid}, 32'd0);
      if (exp_q.size() == 0) begin
        check("rdv_unexpected", {30'b0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rdv_owner", {31'b0, m1_readdatavalid}, {31'b0, e[32]});
        check("readdata", e[32] ? m1_readdata : m0_readdata, e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_m0_waitrequest", m0_waitrequest, 1'b1);
    check("rst_m1_waitrequest", m1_waitrequest, 1'b1);
    check("rst_m0_rdv", m0_readdatavalid, 1'b0);
    check("rst_m1_rdv", m1_readdatavalid, 1'b0);
    check("rst_chipselect", mem_chipselect, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_clken", mem_clken, 1'b0);
    check("rst_oor_error", oor_error, 1'b0);
    reset_n = 1'b1;

    // First read: blocked until ready, accepted after the second edge.
    do_op(1'b0, 1'b0, 14'd0, '0, 4'hF);

    // Write then read back.
    do_op(1'b0, 1'b1, 14'd5, 32'hA5A5_1234, 4'hF);
    do_op(1'b0, 1'b0, 14'd5, '0, 4'hF);

    // Both masters read every cycle: grants alternate.
    set_req(1'b0, 1'b1, 1'b0, 14'd20, '0, 4'hF);
    set_req(1'b1, 1'b1, 1'b0, 14'd21, '0, 4'hF);
    for (int c = 0; c < 6; c++) begin
      step();
      if (gnt0) m0_address = m0_address + 14'd2;
      if (gnt1) m1_address = m1_address + 14'd2;
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
    step();

    // Byte-lane merge on master 1.
    do_op(1'b1, 1'b1, 14'd9, 32'hFFFF_FFFF, 4'hF);
    do_op(1'b1, 1'b1, 14'd9, 32'h0000_0000, 4'b0010);
    do_op(1'b1, 1'b0, 14'd9, '0, 4'hF);
    step();
    check("merge_9", ref_mem[9], 32'hFFFF_00FF);

    // Out of range write and read.
    do_op(1'b0, 1'b1, 14'd10000, 32'hDEAD_BEEF, 4'hF);
    do_op(1'b0, 1'b0, 14'd10000, '0, 4'hF);
    repeat (2) step();

    // Random traffic from both masters.
    for (int c = 0; c < 80; c++) begin
      if (!m0_read && !m0_write) rand_op(1'b0);
      if (!m1_read && !m1_write) rand_op(1'b1);
      step();
      if (gnt0) set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
      if (gnt1) set_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) step();
    check("queue_drained", exp_q.size(), 0);

    // Reset in the cycle after a granted read: pulse is discarded.
    do_op(1'b1, 1'b0, 14'd3, '0, 4'hF);
    reset_n = 1'b0;
    #1;
    check("mid_rst_m0_rdv", m0_readdatavalid, 1'b0);
    check("mid_rst_m1_rdv", m1_readdatavalid, 1'b0);
    check("mid_rst_m0_wait", m0_waitrequest, 1'b1);
    check("mid_rst_m1_wait", m1_waitrequest, 1'b1);
    check("mid_rst_chipselect", mem_chipselect, 1'b0);
    check("mid_rst_clken", mem_clken, 1'b0);
    check("mid_rst_oor_error", oor_error, 1'b0);
    exp_q.delete();
    mdl_ready = 1'b0;
    mdl_last  = 1'b1;
    mdl_oor   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    do_op(1'b1, 1'b0, 14'd5, '0, 4'hF);
    repeat (2) step();
    check("final_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
